// File: rtl/sensor_poll_if.sv
// Request/response link between the poll scheduler (master) and the shared
// I2C controller (slave).
//   req_valid/req_ready/req_addr : read request handshake, addr stable while valid
//   rsp_valid/rsp_error/rsp_data : one-cycle completion pulse with status and reading
interface sensor_poll_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned CU_WIDTH   = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_error;
  logic [CU_WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_error, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_error, rsp_data
  );
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Periodically polls NUM_SENSORS I2C temperature sensors through one shared
// controller, with per-transaction timeout and bounded retries.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : level, gates the start of new rounds
//   sensor_addr_tbl : packed per-channel I2C addresses
//   bus             : request/response link to the I2C controller
//   out_valid/out_channel/out_data : good-reading pulse to temperature_CU
//   fault_mask      : per-channel retries-exhausted flags
//   overrun         : sticky, a period tick hit an active round
//   busy            : a round is in progress
module sensor_poll_scheduler #(
  parameter int unsigned NUM_SENSORS = 4,
  parameter int unsigned CU_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned POLL_PERIOD = 100000,
  parameter int unsigned TIMEOUT     = 20000,
  parameter int unsigned MAX_RETRY   = 2,
  localparam int unsigned CH_W       = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_SENSORS*ADDR_WIDTH-1:0] sensor_addr_tbl,
  sensor_poll_if.master                     bus,
  output logic                              out_valid,
  output logic [CH_W-1:0]                   out_channel,
  output logic [CU_WIDTH-1:0]               out_data,
  output logic [NUM_SENSORS-1:0]            fault_mask,
  output logic                              overrun,
  output logic                              busy
);

  localparam int unsigned PER_W = $clog2(POLL_PERIOD);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] NEXT  = 2'd3;

  logic [1:0]             state, state_nxt;
  logic [PER_W-1:0]       per_cnt, per_cnt_nxt;
  logic [CH_W-1:0]        channel, channel_nxt;
  logic [RTY_W-1:0]       retry, retry_nxt;
  logic [TMO_W-1:0]       tmo, tmo_nxt;
  logic                   req_valid_q, req_valid_nxt;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_nxt;
  logic                   out_valid_nxt;
  logic [CH_W-1:0]        out_channel_nxt;
  logic [CU_WIDTH-1:0]    out_data_nxt;
  logic [NUM_SENSORS-1:0] fault_nxt;
  logic                   overrun_nxt;
  logic                   busy_nxt;
  logic                   tick;

  assign bus.req_valid = req_valid_q;
  assign bus.req_addr  = req_addr_q;

  assign tick = enable && (per_cnt == PER_W'(POLL_PERIOD - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      per_cnt     <= '0;
      channel     <= '0;
      retry       <= '0;
      tmo         <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      fault_mask  <= '0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      per_cnt     <= per_cnt_nxt;
      channel     <= channel_nxt;
      retry       <= retry_nxt;
      tmo         <= tmo_nxt;
      req_valid_q <= req_valid_nxt;
      req_addr_q  <= req_addr_nxt;
      out_valid   <= out_valid_nxt;
      out_channel <= out_channel_nxt;
      out_data    <= out_data_nxt;
      fault_mask  <= fault_nxt;
      overrun     <= overrun_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt       = state;
    channel_nxt     = channel;
    retry_nxt       = retry;
    tmo_nxt         = tmo;
    req_addr_nxt    = req_addr_q;
    out_valid_nxt   = 1'b0;
    out_channel_nxt = out_channel;
    out_data_nxt    = out_data;
    fault_nxt       = fault_mask;
    overrun_nxt     = overrun;
    busy_nxt        = busy;

    // Period counter restarts from 0 whenever enable is low
    if (!enable || tick) per_cnt_nxt = '0;
    else                 per_cnt_nxt = per_cnt + PER_W'(1);

    // A tick outside IDLE is dropped, not queued
    if (tick && (state != IDLE)) overrun_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (tick) begin
          channel_nxt = '0;
          retry_nxt   = '0;
          busy_nxt    = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (req_valid_q && bus.req_ready) begin
          tmo_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response on the last timeout cycle still counts as a response
        if (bus.rsp_valid && !bus.rsp_error) begin
          out_valid_nxt      = 1'b1;
          out_channel_nxt    = channel;
          out_data_nxt       = bus.rsp_data;
          fault_nxt[channel] = 1'b0;
          state_nxt          = NEXT;
        end else if (bus.rsp_valid || (tmo == TMO_W'(TIMEOUT - 1))) begin
          if (retry < RTY_W'(MAX_RETRY)) begin
            retry_nxt = retry + RTY_W'(1);
            state_nxt = ISSUE;
          end else begin
            fault_nxt[channel] = 1'b1;
            state_nxt          = NEXT;
          end
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end
      NEXT: begin
        retry_nxt = '0;
        if (channel == CH_W'(NUM_SENSORS - 1)) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          channel_nxt = channel + CH_W'(1);
          state_nxt   = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    req_valid_nxt = (state_nxt == ISSUE);
    // Address is captured on each entry into ISSUE, one capture per attempt
    if ((state_nxt == ISSUE) && (state != ISSUE))
      req_addr_nxt = sensor_addr_tbl[channel_nxt*ADDR_WIDTH +: ADDR_WIDTH];
  end

endmodule
